// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory-side handshake bundle between the sequencer and the imem/dmem ports.
// master = sequencer (requests, IR latch); slave = memory/datapath side.
interface multicycle_ctrl_fsm_if;
    logic       imem_req;
    logic       imem_ready;
    logic [6:0] instr_op;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;

    modport master (
        output imem_req,
        output ir_we,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  instr_op,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  ir_we,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output instr_op,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I-subset sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// stalls, retire counter and sticky trap on illegal opcode or memory timeout.
// Ports: clk, rst (sync, active high); run gates fetches; br_taken from ALU;
// bus (master) carries imem/dmem handshakes, instr_op and ir_we; datapath
// controls alu_src_imm, alu_a_pc, reg_we, wb_sel, pc_we, pc_sel; status
// trap, trap_cause and instret.
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    br_taken,
    multicycle_ctrl_fsm_if.master   bus,
    output logic                    alu_src_imm,
    output logic                    alu_a_pc,
    output logic                    reg_we,
    output logic [1:0]              wb_sel,
    output logic                    pc_we,
    output logic                    pc_sel,
    output logic                    trap,
    output logic [1:0]              trap_cause,
    output logic [CNT_W-1:0]        instret
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q;

    logic is_ld, is_st, is_br, is_jal, is_auipc, uses_imm, legal;

    assign is_ld    = (op_q == OP_LD);
    assign is_st    = (op_q == OP_ST);
    assign is_br    = (op_q == OP_BR);
    assign is_jal   = (op_q == OP_JAL);
    assign is_auipc = (op_q == OP_AUIPC);
    assign uses_imm = (op_q == OP_I) | is_ld | is_st | is_auipc;
    assign legal    = op_q inside {OP_R, OP_I, OP_LD, OP_ST,
                                   OP_BR, OP_JAL, OP_AUIPC};

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = '0;
        cause_d      = cause_q;
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        alu_src_imm  = 1'b0;
        alu_a_pc     = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                bus.imem_req = run;
                if (run) begin
                    if (bus.imem_ready) begin
                        bus.ir_we = 1'b1;
                        op_d      = bus.instr_op;
                        state_d   = S_DECODE;
                    end else if (cnt_q == WAIT_MAX) begin
                        state_d = S_TRAP;
                        cause_d = 2'd2;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                alu_src_imm = uses_imm;
                alu_a_pc    = is_auipc;
                if (is_br) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken;
                    state_d = S_FETCH;
                end else if (is_ld | is_st) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = is_st;
                // keep the address path selected while the access is open
                alu_src_imm  = 1'b1;
                if (bus.dmem_ready) begin
                    if (is_st) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == WAIT_MAX) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB: begin
                alu_src_imm = uses_imm;
                alu_a_pc    = is_auipc;
                reg_we      = 1'b1;
                pc_we       = 1'b1;
                pc_sel      = is_jal;
                wb_sel      = is_ld ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            cnt_q     <= '0;
            cause_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            if (pc_we) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction cycle traces built from
// the CPI/output rules, compared against the DUT every cycle.
module tb_multicycle_ctrl_fsm;

    localparam int TO = 16;
    localparam int CW = 4;

    localparam bit [6:0] OP_R     = 7'b0110011;
    localparam bit [6:0] OP_I     = 7'b0010011;
    localparam bit [6:0] OP_LD    = 7'b0000011;
    localparam bit [6:0] OP_ST    = 7'b0100011;
    localparam bit [6:0] OP_BR    = 7'b1100011;
    localparam bit [6:0] OP_JAL   = 7'b1101111;
    localparam bit [6:0] OP_AUIPC = 7'b0010111;
    localparam bit [6:0] OP_SYS   = 7'b1110011;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       alu_src_imm;
        logic       alu_a_pc;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic       pc_sel;
        logic       trap;
        logic [1:0] cause;
    } outs_t;

    typedef struct {
        bit          run;
        bit [6:0]    op;
        bit          ir;
        bit          dr;
        bit          br;
        bit          rst;
        outs_t       o;
        logic [CW-1:0] ei;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic br_taken = 1'b0;
    logic alu_src_imm, alu_a_pc, reg_we, pc_we, pc_sel, trap;
    logic [1:0] wb_sel, trap_cause;
    logic [CW-1:0] instret;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .br_taken   (br_taken),
        .bus        (bus.master),
        .alu_src_imm(alu_src_imm),
        .alu_a_pc   (alu_a_pc),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    rec_t q[$];
    rec_t cur;
    bit   cur_v  = 1'b0;

    int       m_cnt   = 0;
    bit       m_trap  = 1'b0;
    bit [1:0] m_cause = 2'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit legal(input bit [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_AUIPC};
    endfunction

    task automatic add(input bit r, input bit [6:0] op, input bit ir,
                       input bit dr, input bit br, input bit rs,
                       input outs_t o);
        rec_t e;
        e.run = r; e.op = op; e.ir = ir; e.dr = dr; e.br = br; e.rst = rs;
        e.o = o;
        e.ei = m_cnt[CW-1:0];
        q.push_back(e);
        if (o.pc_we) m_cnt++;
        if (rs) begin
            m_cnt = 0; m_trap = 1'b0; m_cause = 2'd0;
        end
    endtask

    task automatic idle(input int n);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = '0;
            add(1'b0, OP_R, 1'b1, 1'b1, 1'b1, 1'b0, o);
        end
    endtask

    task automatic fetch_wait(input int n);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = '0; o.imem_req = 1'b1;
            add(1'b1, OP_I, 1'b0, 1'b1, 1'b1, 1'b0, o);
        end
    endtask

    task automatic trap_cycles(input int n);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = '0; o.trap = 1'b1; o.cause = m_cause;
            add(1'b1, OP_I, 1'b1, 1'b1, 1'b1, 1'b0, o);
        end
    endtask

    task automatic do_rst();
        outs_t o;
        o = '0;
        if (m_trap) begin
            o.trap = 1'b1; o.cause = m_cause;
        end
        add(1'b0, OP_R, 1'b0, 1'b0, 1'b0, 1'b1, o);
    endtask

    // Cycle trace of one instruction: fw fetch stalls, mw data stalls.
    task automatic instr(input bit [6:0] op, input int fw, input int mw,
                         input bit br, input bit abort);
        outs_t o;
        bit ld, st, jal, aui, imm;
        ld  = (op == OP_LD);
        st  = (op == OP_ST);
        jal = (op == OP_JAL);
        aui = (op == OP_AUIPC);
        imm = (op == OP_I) || ld || st || aui;
        fetch_wait((fw < TO) ? fw : TO);
        if (fw >= TO) begin
            m_trap = 1'b1; m_cause = 2'd2; return;
        end
        o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1;
        add(1'b1, op, 1'b1, 1'b0, 1'b1, 1'b0, o);
        o = '0;
        add(1'b1, 7'h7f, 1'b1, 1'b1, 1'b1, 1'b0, o);
        if (!legal(op)) begin
            m_trap = 1'b1; m_cause = 2'd1; return;
        end
        o = '0; o.alu_src_imm = imm; o.alu_a_pc = aui;
        if (op == OP_BR) begin
            o.pc_we = 1'b1; o.pc_sel = br;
            add(1'b1, OP_I, 1'b1, 1'b1, br, 1'b0, o);
            return;
        end
        add(1'b1, OP_I, 1'b1, 1'b1, 1'b1, 1'b0, o);
        if (ld || st) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                o = '0; o.dmem_req = 1'b1; o.dmem_we = st; o.alu_src_imm = 1'b1;
                add(1'b1, OP_I, 1'b1, 1'b0, 1'b1, 1'b0, o);
            end
            if (mw >= TO) begin
                m_trap = 1'b1; m_cause = 2'd3; return;
            end
            o = '0; o.dmem_req = 1'b1; o.dmem_we = st; o.alu_src_imm = 1'b1;
            if (abort) begin
                add(1'b1, OP_I, 1'b1, 1'b0, 1'b1, 1'b1, o);
                return;
            end
            o.pc_we = st;
            add(1'b1, OP_I, 1'b1, 1'b1, 1'b1, 1'b0, o);
            if (st) return;
        end
        o = '0; o.reg_we = 1'b1; o.pc_we = 1'b1; o.pc_sel = jal;
        o.wb_sel = ld ? 2'd1 : (jal ? 2'd2 : 2'd0);
        o.alu_src_imm = imm; o.alu_a_pc = aui;
        add(1'b1, OP_I, 1'b1, 1'b1, 1'b1, 1'b0, o);
    endtask

    task automatic run_q();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            rst = r.rst; run = r.run; br_taken = r.br;
            bus.instr_op = r.op; bus.imem_ready = r.ir; bus.dmem_ready = r.dr;
            cur = r; cur_v = 1'b1; cyc++;
        end
        @(negedge clk);
        cur_v = 1'b0;
        rst = 1'b0; run = 1'b0; br_taken = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.instr_op = '0;
        #3;
    endtask

    always @(negedge clk) begin
        outs_t a;
        #2;
        if (cur_v) begin
            a = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
                 alu_src_imm, alu_a_pc, reg_we, wb_sel, pc_we, pc_sel,
                 trap, trap_cause};
            check("outs", 32'(a), 32'(cur.o));
            check("instret", 32'(instret), 32'(cur.ei));
        end
    end

    initial begin
        bus.instr_op = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_req", 32'({bus.imem_req, bus.dmem_req, pc_we}), 32'd0);

        instr(OP_I, 0, 0, 0, 0);
        check("cpi_addi", q.size(), 32'd4);
        run_q();
        check("lit_instret_addi", 32'(instret), 32'd1);

        instr(OP_LD, 0, 3, 0, 0);
        check("cpi_lw_wait3", q.size(), 32'd8);
        run_q();
        check("lit_instret_lw", 32'(instret), 32'd2);

        instr(OP_BR, 0, 0, 1, 0);
        check("cpi_beq", q.size(), 32'd3);
        instr(OP_BR, 0, 0, 0, 0);
        run_q();
        check("lit_instret_br", 32'(instret), 32'd4);

        instr(OP_JAL, 0, 0, 0, 0);
        instr(OP_ST, 0, 0, 0, 0);
        check("cpi_jal_sw", q.size(), 32'd8);
        instr(OP_R, 0, 0, 0, 0);
        instr(OP_AUIPC, 0, 0, 0, 0);
        instr(OP_LD, 0, 0, 0, 0);
        run_q();
        check("lit_instret_mix", 32'(instret), 32'd9);

        fetch_wait(10);
        idle(2);
        instr(OP_I, TO - 1, 0, 0, 0);
        run_q();
        check("lit_ready_at_limit", 32'({trap, instret}), 32'd10);

        for (int i = 0; i < 12; i++) begin
            instr((i % 3 == 0) ? OP_R : ((i % 3 == 1) ? OP_I : OP_AUIPC),
                  i % 2, 0, 0, 0);
        end
        run_q();
        check("lit_instret_wrap", 32'(instret), 32'd6);

        instr(OP_SYS, 0, 0, 0, 0);
        trap_cycles(20);
        run_q();
        check("lit_illegal_cause", 32'({trap, trap_cause}), 32'b101);
        do_rst();
        idle(1);
        run_q();
        check("lit_post_rst", 32'({trap, trap_cause, instret}), 32'd0);

        instr(OP_I, TO, 0, 0, 0);
        check("cpi_imem_timeout", q.size(), 32'(TO));
        trap_cycles(3);
        run_q();
        check("lit_imem_to_cause", 32'({trap, trap_cause}), 32'b110);
        do_rst();
        idle(1);

        instr(OP_ST, 0, TO, 0, 0);
        trap_cycles(3);
        run_q();
        check("lit_dmem_to_cause", 32'({trap, trap_cause}), 32'b111);
        do_rst();
        idle(1);

        instr(OP_LD, 0, 2, 0, 1);
        idle(1);
        run_q();
        check("lit_abort_dmem_req", 32'({bus.dmem_req, instret}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
